// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// ALU-op codes, datapath mux selects and the packed control vector.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_HALT      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LOGIC = 2'b11
  } alu_op_e;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
  } ctrl_t;

  // I-type ALU subset: ADDI adds, SLTI compares, the rest are logical.
  function automatic alu_op_e i_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_SLTI: return ALU_SUB;
      default: return ALU_LOGIC;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the registered state and latched opcode to the
// datapath control vector. mem_ready only gates the FETCH-cycle IR/PC loads.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  state_e              state,
  input  logic [OPCODE_W-1:0] op_q,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case, so no path can infer a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = i_alu_op(op_q[5:0]);
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, latched opcode, sticky illegal flag.
// Optional MCU_MEM_WAIT_EN adds mem_ready so memory states stall until ready.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int ALU_OP_W     = 2,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
`ifdef MCU_MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
);

  state_e              state, state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic                op_known;
  logic                mem_go;
  ctrl_t               ctrl;

`ifdef MCU_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        op_q <= opcode;
        if (!op_known) illegal_op <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    op_known = 1'b1;
    case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: if (mem_go) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nx = S_R_EXEC;
          OP_LW, OP_SW: state_nx = S_MEM_ADDR;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                        state_nx = S_I_EXEC;
          default: begin
            op_known = 1'b0;
            state_nx = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR:  state_nx = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_go) state_nx = S_MEM_WB;
      S_MEM_WRITE: if (mem_go) state_nx = S_FETCH;
      S_R_EXEC:    state_nx = S_R_WB;
      S_I_EXEC:    state_nx = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB:
                   state_nx = S_FETCH;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_IDLE;
    endcase
  end

  mips_ctrl_outdec #(
    .OPCODE_W (OPCODE_W)
  ) u_outdec (
    .state     (state),
    .op_q      (op_q),
    .mem_ready (mem_go),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALU_OP_W'(ctrl.alu_op);
  assign state_dbg     = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: two controllers (trap / no-trap) against a path-based
// instruction model, directed scenarios followed by randomized opcodes and resets.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, JMP = 6'h02, RT = 6'h00;
  localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0c, ORI = 6'h0d, XORI = 6'h0e, SLTI = 6'h0a;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_rdy;

  logic [1:0] pc_source[2], alu_src_b[2], alu_op[2];
  logic       pc_write[2], pc_write_cond[2], i_or_d[2], mem_read[2], mem_write[2];
  logic       ir_write[2], reg_dst[2], mem_to_reg[2], reg_write[2], alu_src_a[2], illegal_op[2];
  logic [3:0] state_dbg[2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
`ifdef MCU_MEM_WAIT_EN
    .mem_ready(mem_rdy),
`endif
    .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]), .pc_source(pc_source[0]),
    .i_or_d(i_or_d[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .ir_write(ir_write[0]), .reg_dst(reg_dst[0]), .mem_to_reg(mem_to_reg[0]),
    .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
    .alu_op(alu_op[0]), .illegal_op(illegal_op[0]), .state_dbg(state_dbg[0])
  );

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(0)) dut_nt (
    .clk(clk), .rst(rst), .opcode(opcode),
`ifdef MCU_MEM_WAIT_EN
    .mem_ready(mem_rdy),
`endif
    .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]), .pc_source(pc_source[1]),
    .i_or_d(i_or_d[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .ir_write(ir_write[1]), .reg_dst(reg_dst[1]), .mem_to_reg(mem_to_reg[1]),
    .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
    .alu_op(alu_op[1]), .illegal_op(illegal_op[1]), .state_dbg(state_dbg[1])
  );

  // Reference model: each instruction is a fixed list of post-DECODE steps.
  int         m_state[2];
  int         m_k[2];
  logic [5:0] m_op[2];
  logic       m_ill[2];

  function automatic int path_at(input logic [5:0] op, input int k);
    int p[$];
    case (op)
      LW:   p = '{3, 4, 5};
      SW:   p = '{3, 6};
      RT:   p = '{7, 8};
      BEQ:  p = '{9};
      JMP:  p = '{10};
      ADDI, ANDI, ORI, XORI, SLTI: p = '{11, 12};
      default: p = {};
    endcase
    return (k < p.size()) ? p[k] : -1;
  endfunction

  function automatic logic rdy_now();
`ifdef MCU_MEM_WAIT_EN
    return mem_rdy;
`else
    return 1'b1;
`endif
  endfunction

  // Expected control vector, packed as {pc_write, pc_write_cond, pc_source, i_or_d,
  // mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op}.
  function automatic logic [15:0] exp_ctrl(input int s, input logic [5:0] op, input logic rdy);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] ps = 0, sb = 0, ao = 0;
    case (s)
      1:  begin mr = 1; irw = rdy; pw = rdy; sb = 2'b01; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iod = 1; end
      7:  begin sa = 1; ao = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      10: begin pw = 1; ps = 2'b10; end
      11: begin sa = 1; sb = 2'b10; ao = (op == ADDI) ? 2'b00 : (op == SLTI) ? 2'b01 : 2'b11; end
      12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao};
  endfunction

  function automatic logic [15:0] got_ctrl(input int i);
    return {pc_write[i], pc_write_cond[i], pc_source[i], i_or_d[i], mem_read[i], mem_write[i],
            ir_write[i], reg_dst[i], mem_to_reg[i], reg_write[i], alu_src_a[i], alu_src_b[i], alu_op[i]};
  endfunction

  task automatic model_update(input int i);
    bit trap = (i == 0);
    int s;
    if (rst) begin
      m_state[i] = 0; m_op[i] = '0; m_ill[i] = 0; m_k[i] = 0;
    end else begin
      case (m_state[i])
        0:  m_state[i] = 1;
        1:  if (rdy_now()) m_state[i] = 2;
        2: begin
          m_op[i] = opcode;
          m_k[i]  = 0;
          s = path_at(opcode, 0);
          if (s < 0) begin
            m_ill[i]   = 1;
            m_state[i] = trap ? 13 : 1;
          end else m_state[i] = s;
        end
        13: ;
        default: begin
          if (!((m_state[i] == 4 || m_state[i] == 6) && !rdy_now())) begin
            m_k[i]++;
            s = path_at(m_op[i], m_k[i]);
            m_state[i] = (s < 0) ? 1 : s;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare both DUTs against the model, then advance one clock.
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("state%0d", i), 32'(state_dbg[i]), 32'(m_state[i]));
      check($sformatf("ctrl%0d_s%0d", i, m_state[i]), 32'(got_ctrl(i)),
            32'(exp_ctrl(m_state[i], m_op[i], rdy_now())));
      check($sformatf("illegal%0d", i), 32'(illegal_op[i]), 32'(m_ill[i]));
      check($sformatf("mutex%0d", i), {30'd0, mem_read[i] & mem_write[i], reg_write[i] & pc_write[i]}, 32'd0);
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  // Entry precondition: both DUTs in FETCH with mem_rdy=1.
  task automatic run_instr(input string tag, input logic [5:0] op, input bit scramble,
                           input logic [5:0] alt, input int exp_len);
    int n = 0;
    opcode = op;
    do begin
      step();
      n++;
      if (scramble && n == 2) opcode = alt;
    end while (state_dbg[0] !== 4'd1 && n < 40);
    check({tag, "_latency"}, 32'(n), 32'(exp_len));
  endtask

  logic [5:0] legal_ops[10] = '{LW, SW, BEQ, JMP, RT, ADDI, ANDI, ORI, XORI, SLTI};

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_k[i] = 0; m_op[i] = '0; m_ill[i] = 0;
    end
    rst = 1'b1; opcode = '0; mem_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (3) step();

    rst = 1'b0;
    step();
    check("fetch_strobes", {29'd0, mem_read[0], ir_write[0], pc_write[0]}, 32'h7);

    run_instr("lw",   LW,   0, LW, 5);
    run_instr("slti", SLTI, 1, RT, 4);
    run_instr("beq",  BEQ,  0, BEQ, 3);
    run_instr("j",    JMP,  0, JMP, 3);
    run_instr("sw",   SW,   0, SW, 4);
    run_instr("rtyp", RT,   0, RT, 4);
    run_instr("andi", ANDI, 0, ANDI, 4);

    // Reset during MEM_WRITE.
    opcode = SW;
    for (int n = 0; n < 10 && state_dbg[0] !== 4'd6; n++) step();
    check("sw_reach_memwrite", 32'(state_dbg[0]), 32'd6);
    rst = 1'b1;
    step();
    check("rst_in_memwrite_state", 32'(state_dbg[0]), 32'd0);
    check("rst_in_memwrite_mw", 32'(mem_write[0]), 32'd0);
    rst = 1'b0;
    step();

    // Illegal opcode: trap instance halts, no-trap instance returns to FETCH.
    opcode = 6'h3f;
    step();
    step();
    check("trap_halt", 32'(state_dbg[0]), 32'd13);
    check("notrap_fetch", 32'(state_dbg[1]), 32'd1);
    check("trap_illegal", 32'(illegal_op[0]), 32'd1);
    check("notrap_illegal", 32'(illegal_op[1]), 32'd1);
    opcode = RT;
    repeat (20) step();
    check("halt_held", 32'(state_dbg[0]), 32'd13);
    rst = 1'b1;
    step();
    check("rst_from_halt", 32'(state_dbg[0]), 32'd0);
    check("illegal_cleared", 32'(illegal_op[0]), 32'd0);
    rst = 1'b0;
    step();

`ifdef MCU_MEM_WAIT_EN
    mem_rdy = 1'b0;
    repeat (3) begin
      step();
      check("wait_fetch_held", 32'(state_dbg[0]), 32'd1);
      check("wait_no_ir_write", 32'(ir_write[0]), 32'd0);
    end
    mem_rdy = 1'b1;
    #1;
    check("ready_ir_write", 32'(ir_write[0]), 32'd1);
    run_instr("lw_after_wait", LW, 0, LW, 5);
`endif

    for (int c = 0; c < 1500; c++) begin
      opcode  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
`ifdef MCU_MEM_WAIT_EN
      mem_rdy = ($urandom_range(0, 3) != 0);
`endif
      rst     = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;
    mem_rdy = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
